// File: rtl/rf_pkg.sv
// Shared types for the scrubbing register file.
package rf_pkg;

  typedef enum logic {RF_SCRUB, RF_READY} rf_state_t;

endpackage

// File: rtl/rf_read_port.sv
// One register-file read port: entry mux, same-cycle write bypass, not-ready masking.
module rf_read_port #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1,
  localparam int unsigned AW      = $clog2(DEPTH)
) (
  input  logic              ready,
  input  logic [AW-1:0]     rd_addr,
  input  logic              byp_ena,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] mem [DEPTH],
  output logic [DATA_W-1:0] rd_data
);

  // byp_ena already excludes dropped writes (not ready, clr, hardwired entry 0)
  always_comb begin
    rd_data = '0;
    if (ready) begin
      if ((ZERO_REG != 0) && (rd_addr == '0)) begin
        rd_data = '0;
      end else if ((BYPASS != 0) && byp_ena && (rd_addr == wr_addr)) begin
        rd_data = wr_data;
      end else begin
        rd_data = mem[rd_addr];
      end
    end
  end

endmodule

// File: rtl/register_file_scrub.sv
// Multi-port flop register file with a post-reset / on-demand scrub that zeroes every entry.
module register_file_scrub
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned N_RD     = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1,
  localparam int unsigned AW      = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   wr_ena,
  input  logic [AW-1:0]          wr_addr,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic [N_RD*AW-1:0]     rd_addr,
  output logic [N_RD*DATA_W-1:0] rd_data,
  output logic                   ready
);

  localparam logic [AW-1:0] FIRST = (ZERO_REG != 0) ? AW'(1) : AW'(0);
  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

  rf_state_t         state_q, state_d;
  logic [AW-1:0]     ptr_q, ptr_d;
  logic              scrub_we;
  logic              user_we;
  logic [DEPTH-1:0]  ent_we;
  logic [DATA_W-1:0] ent_wd;
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RF_SCRUB;
      ptr_q   <= FIRST;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // clr restarts the scrub from FIRST in either state and drops any concurrent write
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    scrub_we = 1'b0;
    user_we  = 1'b0;
    case (state_q)
      RF_SCRUB: begin
        scrub_we = 1'b1;
        if (clr) begin
          ptr_d = FIRST;
        end else begin
          ptr_d = ptr_q + AW'(1);
          if (ptr_q == LAST) state_d = RF_READY;
        end
      end
      RF_READY: begin
        if (clr) begin
          state_d = RF_SCRUB;
          ptr_d   = FIRST;
        end else if (wr_ena && !((ZERO_REG != 0) && (wr_addr == '0))) begin
          user_we = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    ent_we = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      ent_we[k] = (scrub_we && (ptr_q == AW'(k))) || (user_we && (wr_addr == AW'(k)));
    end
  end

  assign ent_wd = scrub_we ? '0 : wr_data;

  // Storage: per-entry enabled flops, no reset (scrub defines contents)
  always_ff @(posedge clk) begin
    for (int k = 0; k < int'(DEPTH); k++) begin
      if (ent_we[k]) mem[k] <= ent_wd;
    end
  end

  assign ready = (state_q == RF_READY);

  for (genvar i = 0; i < int'(N_RD); i++) begin : g_rd
    rf_read_port #(
      .DATA_W  (DATA_W),
      .DEPTH   (DEPTH),
      .ZERO_REG(ZERO_REG),
      .BYPASS  (BYPASS)
    ) u_port (
      .ready  (ready),
      .rd_addr(rd_addr[i*AW +: AW]),
      .byp_ena(user_we),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .mem    (mem),
      .rd_data(rd_data[i*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_register_file_scrub.sv
// Directed bench: default build (hardwired zero, bypass) alongside a ZERO_REG=0/BYPASS=0 build.
module tb_register_file_scrub;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned AW     = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clr = 1'b0;
  logic              wr_ena = 1'b0;
  logic [AW-1:0]     wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic [2*AW-1:0]   rd_addr = '0;
  logic [2*DATA_W-1:0] rd_data, rd_data_alt;
  logic              ready, ready_alt;

  int checks = 0;
  int errors = 0;

  register_file_scrub dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_ena(wr_ena), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data), .ready(ready)
  );

  register_file_scrub #(.ZERO_REG(0), .BYPASS(0)) dut_alt (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_ena(wr_ena), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data_alt), .ready(ready_alt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  function automatic logic [DATA_W-1:0] port(input logic [2*DATA_W-1:0] v, input int p);
    return v[p*DATA_W +: DATA_W];
  endfunction

  task automatic write_entry(input logic [AW-1:0] a, input logic [DATA_W-1:0] d);
    @(negedge clk);
    wr_ena = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_ena = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b0 || ready_alt !== 1'b0 || rd_data !== '0) begin
      errors++;
      $display("FAIL reset_state: ready=%b ready_alt=%b rd_data=%h required 0/0/0", ready, ready_alt, rd_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 32; e++) begin
      @(posedge clk); #1;
      rd_addr = {AW'(e % 32), AW'((e * 7) % 32)};
      #1;
      checks++;
      if (ready !== (e >= 31) || ready_alt !== (e >= 32)) begin
        errors++;
        $display("FAIL scrub_ready edge %0d: ready=%b ready_alt=%b required %b/%b",
                 e, ready, ready_alt, e >= 31, e >= 32);
      end
      if (e < 31) begin
        checks++;
        if (rd_data !== '0) begin
          errors++;
          $display("FAIL scrub_mask edge %0d: rd_data=%h required 0", e, rd_data);
        end
      end
    end
    for (int a = 0; a < 32; a++) begin
      @(negedge clk);
      rd_addr = {AW'(31 - a), AW'(a)};
      #1;
      checks++;
      if (rd_data !== '0 || rd_data_alt !== '0) begin
        errors++;
        $display("FAIL scrub_zero addr %0d: rd_data=%h rd_data_alt=%h required 0", a, rd_data, rd_data_alt);
      end
    end
  endtask

  task automatic test_write_read;
    write_entry(5'd5, 32'hDEAD_BEEF);
    rd_addr = {5'd5, 5'd5};
    #1;
    checks++;
    if (port(rd_data, 0) !== 32'hDEAD_BEEF || port(rd_data, 1) !== 32'hDEAD_BEEF ||
        port(rd_data_alt, 0) !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL write_read: rd_data=%h rd_data_alt=%h required DEADBEEF on both ports", rd_data, rd_data_alt);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    wr_ena = 1'b1; wr_addr = 5'd20; wr_data = 32'h0000_00A1;
    @(negedge clk);
    wr_addr = 5'd21; wr_data = 32'h0000_00B2;
    @(negedge clk);
    wr_ena = 1'b0;
    rd_addr = {5'd21, 5'd20};
    #1;
    checks++;
    if (port(rd_data, 0) !== 32'h0000_00A1 || port(rd_data, 1) !== 32'h0000_00B2) begin
      errors++;
      $display("FAIL back_to_back: rd_data=%h required 000000B2_000000A1", rd_data);
    end
  endtask

  task automatic test_zero_reg;
    write_entry(5'd0, 32'hFFFF_FFFF);
    rd_addr = {5'd0, 5'd0};
    #1;
    checks++;
    if (port(rd_data, 0) !== 32'h0 || port(rd_data, 1) !== 32'h0) begin
      errors++;
      $display("FAIL zero_reg: rd_data=%h required 0", rd_data);
    end
    checks++;
    if (port(rd_data_alt, 0) !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL zero_reg_off: rd_data_alt0=%h required FFFFFFFF", port(rd_data_alt, 0));
    end
  endtask

  task automatic test_bypass;
    @(negedge clk);
    wr_ena = 1'b1; wr_addr = 5'd7; wr_data = 32'h0000_1234;
    rd_addr = {5'd5, 5'd7};
    #1;
    checks++;
    if (port(rd_data, 0) !== 32'h0000_1234 || port(rd_data, 1) !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL bypass_on: rd_data=%h required DEADBEEF_00001234", rd_data);
    end
    checks++;
    if (port(rd_data_alt, 0) !== 32'h0) begin
      errors++;
      $display("FAIL bypass_off: rd_data_alt0=%h required 0 (old value)", port(rd_data_alt, 0));
    end
    @(negedge clk);
    wr_addr = 5'd0; wr_data = 32'h5555_5555;
    rd_addr = {5'd7, 5'd0};
    #1;
    checks++;
    if (port(rd_data, 0) !== 32'h0 || port(rd_data, 1) !== 32'h0000_1234 ||
        port(rd_data_alt, 0) !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL bypass_zero: rd_data=%h rd_data_alt0=%h required 00001234_00000000 / FFFFFFFF",
               rd_data, port(rd_data_alt, 0));
    end
    @(negedge clk);
    wr_ena = 1'b0;
  endtask

  task automatic test_clr;
    for (int a = 1; a < 32; a++) write_entry(AW'(a), DATA_W'(a));
    rd_addr = {5'd31, 5'd10};
    #1;
    checks++;
    if (port(rd_data, 0) !== 32'd10 || port(rd_data, 1) !== 32'd31) begin
      errors++;
      $display("FAIL fill: rd_data=%h required 0000001F_0000000A", rd_data);
    end
    @(negedge clk);
    clr = 1'b1; wr_ena = 1'b1; wr_addr = 5'd10; wr_data = 32'h0000_00AA;
    #1;
    checks++;
    if (ready !== 1'b1 || port(rd_data, 0) !== 32'd10) begin
      errors++;
      $display("FAIL clr_no_bypass: ready=%b rd_data0=%h required 1/0000000A", ready, port(rd_data, 0));
    end
    @(negedge clk);
    clr = 1'b0; wr_ena = 1'b0;
    checks++;
    if (ready !== 1'b0 || ready_alt !== 1'b0) begin
      errors++;
      $display("FAIL clr_enter: ready=%b ready_alt=%b required 0/0", ready, ready_alt);
    end
    for (int e = 1; e <= 32; e++) begin
      @(posedge clk); #1;
      checks++;
      if (ready !== (e >= 31) || ready_alt !== (e >= 32)) begin
        errors++;
        $display("FAIL clr_scrub edge %0d: ready=%b ready_alt=%b required %b/%b",
                 e, ready, ready_alt, e >= 31, e >= 32);
      end
    end
    for (int a = 0; a < 32; a++) begin
      @(negedge clk);
      rd_addr = {AW'(a), AW'(31 - a)};
      #1;
      checks++;
      if (rd_data !== '0 || rd_data_alt !== '0) begin
        errors++;
        $display("FAIL clr_zero addr %0d: rd_data=%h rd_data_alt=%h required 0", a, rd_data, rd_data_alt);
      end
    end
  endtask

  task automatic test_reset_mid_scrub;
    write_entry(5'd3, 32'h0000_0055);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wr_ena = 1'b1; wr_addr = 5'd3; wr_data = 32'h0000_0077;
    for (int e = 1; e <= 10; e++) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b0 || rd_data !== '0) begin
      errors++;
      $display("FAIL reset_mid_scrub: ready=%b rd_data=%h required 0/0", ready, rd_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 32; e++) begin
      @(posedge clk); #1;
      if (e == 30) wr_ena = 1'b0;
      checks++;
      if (ready !== (e >= 31) || ready_alt !== (e >= 32)) begin
        errors++;
        $display("FAIL rescrub edge %0d: ready=%b ready_alt=%b required %b/%b",
                 e, ready, ready_alt, e >= 31, e >= 32);
      end
    end
    @(negedge clk);
    rd_addr = {5'd3, 5'd3};
    #1;
    checks++;
    if (rd_data !== '0 || rd_data_alt !== '0) begin
      errors++;
      $display("FAIL scrub_write_dropped: rd_data=%h rd_data_alt=%h required 0", rd_data, rd_data_alt);
    end
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_back_to_back;
    test_zero_reg;
    test_bypass;
    test_clr;
    test_reset_mid_scrub;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
